cim_mem_responder: RTL and testbench
====================================

CIM_MEM_RESPONDER -- requirements
Module: cim_mem_responder

Interface
REQ-001 SHALL have parameter N_SRC, default MEM_ACCESS_SRC_NUM (5), the number of requesters (BUS_FSM=0, LOGIC_FSM=1, MAC=2, LAYERNORM=3, SOFTMAX=4).
REQ-002 SHALL have parameter ADDR_W, default $clog2(TEMP_RES_STORAGE_SIZE_CIM), the temp-storage address width.
REQ-003 SHALL have parameter DATA_W, default N_STORAGE, the word width.
REQ-004 SHALL have parameter SRAM_LAT, default 1, the SRAM read latency in cycles (legal range 1..3).
REQ-005 SHALL have parameter STARVE_LIM, default 4, the consecutive-denial count that promotes a source.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports read_req_src and write_req_src, input, N_SRC bits each: per-source read and write requests.
REQ-009 SHALL have port addr_table, input, N_SRC x ADDR_W: the per-source address.
REQ-010 SHALL have port write_data, input, N_SRC x DATA_W: the per-source write word.
REQ-011 SHALL have port grant, output, N_SRC bits: one-hot (or zero), combinational, marking the request accepted this cycle.
REQ-012 SHALL have ports sram_en, sram_wen, sram_addr and sram_wdata, outputs (1, 1, ADDR_W, DATA_W bits): the single-port SRAM command.
REQ-013 SHALL have port sram_rdata, input, DATA_W: the SRAM read data.
REQ-014 SHALL have port rd_data, output, DATA_W: the returned read word.
REQ-015 SHALL have port rd_valid, output, N_SRC bits: a one-hot tag naming the source that owns rd_data.
REQ-016 SHALL have port addr_err, output, 1 bit: a sticky out-of-range address flag.

Function
REQ-017 SHALL issue at most one SRAM access per cycle; a source with a request pending is "active".
REQ-018 SHALL grant by fixed priority, lowest index first, unless one or more sources are promoted; promoted sources then win, lowest index among the promoted.
REQ-019 SHALL keep a 3-bit denial counter per source: increment when active but not granted, clear when granted or idle, saturate at STARVE_LIM; a source is promoted while its counter equals STARVE_LIM.
REQ-020 SHALL, when the granted source asserts both read and write in one cycle, perform the write; the read stays pending, and the source holds it and receives no grant for it that cycle.
REQ-021 SHALL require denied sources to hold request, address and data stable until granted; the block does not buffer denied requests.
REQ-022 SHALL, for a granted access, drive sram_en=1 and sram_addr=addr_table[g] in the same cycle; for a write also sram_wen=1 and sram_wdata=write_data[g].
REQ-023 SHALL, for a granted read, assert rd_valid with the granted bit exactly SRAM_LAT cycles after the grant, with rd_data=sram_rdata; this is a pipelined tag shift register, so back-to-back reads are supported at 1 per cycle.
REQ-024 SHALL, when no read tag is due, drive rd_valid=0 and rd_data=0.
REQ-025 SHALL, for a granted address >= TEMP_RES_STORAGE_SIZE_CIM, suppress sram_en, still assert grant, set addr_err, and for a read return rd_data=0 with rd_valid at the normal latency.
REQ-026 SHALL, with no active source, drive grant=0, sram_en=0 and sram_wen=0.

Reset
REQ-027 SHALL, while rst=1, force grant=0, sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, rd_valid=0, rd_data=0, addr_err=0, and all denial counters to 0.
REQ-028 SHALL discard in-flight read tags on reset mid-operation; no rd_valid is issued for reads granted before reset.
REQ-029 SHALL clear addr_err only by reset.

Configuration
REQ-030 SHALL, when CIM_MEM_COLLISION_CNT_EN is defined, add output collision_cnt (16 bits, reset 0) that increments once per cycle with two or more active sources and saturates at 0xFFFF.
REQ-031 SHALL, when CIM_MEM_COLLISION_CNT_EN is undefined, omit the collision_cnt port and its logic; all other behaviour is unchanged.

Verification
REQ-032 SHALL be verified by: MAC write addr 10, data 0x1234; LAYERNORM read addr 10 the next cycle -> grant[3] and rd_valid=5'b01000 with rd_data=0x1234 SRAM_LAT cycles later.
REQ-033 SHALL be verified by: BUS_FSM and SOFTMAX both reading continuously -> BUS_FSM is granted for 4 cycles, SOFTMAX is promoted and granted on the 5th, then BUS_FSM resumes.
REQ-034 SHALL be verified by: LOGIC_FSM asserting read and write to addr 7 in the same cycle -> the write is granted first and the read the following cycle, returning the new data.
REQ-035 SHALL be verified by: MAC read at address TEMP_RES_STORAGE_SIZE_CIM -> sram_en=0, addr_err=1 and stays 1, rd_valid[2] asserted with rd_data=0.
REQ-036 SHALL be verified by: rst pulsed one cycle after a read grant -> no rd_valid ever appears for that read and all outputs are 0 during reset.
REQ-037 SHALL be verified, with CIM_MEM_COLLISION_CNT_EN defined, by: 3 cycles of 2+ active sources -> collision_cnt=3.

Source files
------------

// File: rtl/cim_mem_responder.sv
// Arbitrated single-port temp-storage responder with starvation promotion and tagged read return.
// Define CIM_MEM_COLLISION_CNT_EN to add the saturating collision_cnt output.
module cim_mem_responder #(
    parameter int MEM_ACCESS_SRC_NUM        = 5,
    parameter int TEMP_RES_STORAGE_SIZE_CIM = 48,
    parameter int N_STORAGE                 = 16,
    parameter int N_SRC                     = MEM_ACCESS_SRC_NUM,
    parameter int ADDR_W                    = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
    parameter int DATA_W                    = N_STORAGE,
    parameter int SRAM_LAT                  = 1,
    parameter int STARVE_LIM                = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_SRC-1:0]               read_req_src,
    input  logic [N_SRC-1:0]               write_req_src,
    input  logic [N_SRC-1:0][ADDR_W-1:0]   addr_table,
    input  logic [N_SRC-1:0][DATA_W-1:0]   write_data,
    output logic [N_SRC-1:0]               grant,
    output logic                           sram_en,
    output logic                           sram_wen,
    output logic [ADDR_W-1:0]              sram_addr,
    output logic [DATA_W-1:0]              sram_wdata,
    input  logic [DATA_W-1:0]              sram_rdata,
    output logic [DATA_W-1:0]              rd_data,
    output logic [N_SRC-1:0]               rd_valid,
    output logic                           addr_err
`ifdef CIM_MEM_COLLISION_CNT_EN
    ,
    output logic [15:0]                    collision_cnt
`endif
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [2:0] LIM = 3'(STARVE_LIM);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(TEMP_RES_STORAGE_SIZE_CIM);

    logic [N_SRC-1:0]                 active;
    logic [N_SRC-1:0]                 promoted;
    logic [N_SRC-1:0]                 pool;
    logic                             have_g;
    logic [IDX_W-1:0]                 g_idx;
    logic [N_SRC-1:0]                 g_vec;
    logic                             g_wr;
    logic [ADDR_W-1:0]                g_addr;
    logic                             g_oob;

    logic [N_SRC-1:0][2:0]            cnt_q;
    logic [N_SRC-1:0][2:0]            cnt_d;
    logic [SRAM_LAT-1:0][N_SRC-1:0]   tag_q;
    logic [SRAM_LAT-1:0][N_SRC-1:0]   tag_d;
    logic [SRAM_LAT-1:0]              err_q;
    logic [SRAM_LAT-1:0]              err_d;
    logic                             addr_err_q;
    logic                             addr_err_d;

    // Promoted sources form the candidate pool when any exist; lowest index wins.
    always_comb begin
        active   = read_req_src | write_req_src;
        promoted = '0;
        for (int i = 0; i < N_SRC; i++) begin
            promoted[i] = active[i] && (cnt_q[i] == LIM);
        end
        pool   = (|promoted) ? promoted : active;
        have_g = |pool;
        g_idx  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pool[i]) begin
                g_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        g_vec  = '0;
        g_wr   = 1'b0;
        g_addr = addr_table[g_idx];
        g_oob  = ({1'b0, g_addr} >= ADDR_LIMIT);
        if (have_g) begin
            g_vec = N_SRC'(1) << g_idx;
            g_wr  = write_req_src[g_idx];
        end
    end

    // A simultaneous read+write is taken as the write; the read waits.
    always_comb begin
        grant      = '0;
        sram_en    = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!rst && have_g) begin
            grant     = g_vec;
            sram_en   = !g_oob;
            sram_wen  = g_wr && !g_oob;
            sram_addr = g_addr;
            if (g_wr) begin
                sram_wdata = write_data[g_idx];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (!active[i] || g_vec[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != LIM) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end
        end
    end

    always_comb begin
        tag_d    = '0;
        err_d    = '0;
        tag_d[0] = (have_g && !g_wr) ? g_vec : '0;
        err_d[0] = have_g && !g_wr && g_oob;
        for (int k = 1; k < SRAM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
            err_d[k] = err_q[k-1];
        end
        addr_err_d = addr_err_q || (have_g && g_oob);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tag_q      <= '0;
            err_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Out-of-range reads still return a tag, but with zero data.
    always_comb begin
        rd_valid = tag_q[SRAM_LAT-1];
        rd_data  = '0;
        if ((|tag_q[SRAM_LAT-1]) && !err_q[SRAM_LAT-1]) begin
            rd_data = sram_rdata;
        end
    end

    assign addr_err = addr_err_q;

`ifdef CIM_MEM_COLLISION_CNT_EN
    logic [15:0] coll_q;
    logic [15:0] coll_d;
    logic [$clog2(N_SRC+1)-1:0] n_act;

    always_comb begin
        n_act = '0;
        for (int i = 0; i < N_SRC; i++) begin
            n_act = n_act + {{($clog2(N_SRC+1)-1){1'b0}}, active[i]};
        end
        coll_d = coll_q;
        if ((n_act >= 2) && (coll_q != 16'hFFFF)) begin
            coll_d = coll_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= '0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision_cnt = coll_q;
`endif

endmodule

// File: tb/tb_cim_mem_responder.sv
// Randomized bench for cim_mem_responder with an arbitration/memory reference model.
// Define CIM_MEM_COLLISION_CNT_EN to also check collision_cnt.
module tb_cim_mem_responder;

    localparam int NS   = 5;
    localparam int SIZE = 48;
    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int LIM  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NS-1:0]          rreq;
    logic [NS-1:0]          wreq;
    logic [NS-1:0][AW-1:0]  addr;
    logic [NS-1:0][DW-1:0]  wdat;
    logic [NS-1:0]          grant;
    logic                   sram_en;
    logic                   sram_wen;
    logic [AW-1:0]          sram_addr;
    logic [DW-1:0]          sram_wdata;
    logic [DW-1:0]          sram_rdata;
    logic [DW-1:0]          rd_data;
    logic [NS-1:0]          rd_valid;
    logic                   addr_err;
`ifdef CIM_MEM_COLLISION_CNT_EN
    logic [15:0]            collision_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cim_mem_responder #(
        .MEM_ACCESS_SRC_NUM(NS),
        .TEMP_RES_STORAGE_SIZE_CIM(SIZE),
        .N_STORAGE(DW),
        .SRAM_LAT(LAT),
        .STARVE_LIM(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .read_req_src(rreq),
        .write_req_src(wreq),
        .addr_table(addr),
        .write_data(wdat),
        .grant(grant),
        .sram_en(sram_en),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .addr_err(addr_err)
`ifdef CIM_MEM_COLLISION_CNT_EN
        ,
        .collision_cnt(collision_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed_word(int i);
        return DW'(i * 40503 + 7);
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // SRAM fixture with LAT-cycle read latency; idle slots carry junk data.
    logic [DW-1:0] sram_mem [64];
    logic [DW-1:0] rpipe [LAT];
    bit            filled = 1'b0;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= seed_word(i);
            filled <= 1'b1;
        end else if (sram_en && sram_wen) begin
            sram_mem[sram_addr] <= sram_wdata;
        end
        rpipe[0] <= (sram_en && !sram_wen) ? sram_mem[sram_addr] : DW'($urandom);
        for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end

    assign sram_rdata = rpipe[LAT-1];

    // Reference model state
    logic [DW-1:0] mmem [64];
    int            wait_c [NS];
    bit            merr;
    int            cyc = 0;
    logic [NS-1:0] sched_v [int];
    logic [DW-1:0] sched_d [int];
    logic [NS-1:0] last_gnt = '0;
`ifdef CIM_MEM_COLLISION_CNT_EN
    int            coll;
`endif

    always @(negedge clk) begin : cmp
        int            win;
        bit            oob;
        logic [NS-1:0] act;
        logic [NS-1:0] eg;
        logic [NS-1:0] erv;
        logic [DW-1:0] erd;
        logic [DW-1:0] ewd;
        logic [AW-1:0] ea;
        logic          een;
        logic          ewen;
        cyc++;
        if (cyc == 1) begin
            for (int i = 0; i < 64; i++) mmem[i] = seed_word(i);
        end
        if (rst) begin
            chk("rst_grant", grant, 0);
            chk("rst_en", sram_en, 0);
            chk("rst_wen", sram_wen, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_wdata", sram_wdata, 0);
            chk("rst_rv", rd_valid, 0);
            chk("rst_rd", rd_data, 0);
            chk("rst_err", addr_err, 0);
            for (int i = 0; i < NS; i++) wait_c[i] = 0;
            merr = 1'b0;
            sched_v.delete();
            sched_d.delete();
            last_gnt = '0;
`ifdef CIM_MEM_COLLISION_CNT_EN
            chk("rst_coll", collision_cnt, 0);
            coll = 0;
`endif
        end else begin
            act = rreq | wreq;
            win = -1;
            for (int i = 0; i < NS; i++)
                if (act[i] && wait_c[i] >= LIM && win < 0) win = i;
            for (int i = 0; i < NS; i++)
                if (act[i] && win < 0) win = i;
            eg = '0; een = 0; ewen = 0; ea = '0; ewd = '0; oob = 0;
            if (win >= 0) begin
                eg[win] = 1'b1;
                oob  = (int'(addr[win]) >= SIZE);
                een  = !oob;
                ewen = wreq[win] && !oob;
                ea   = addr[win];
                ewd  = wreq[win] ? wdat[win] : '0;
            end
            erv = sched_v.exists(cyc) ? sched_v[cyc] : '0;
            erd = sched_d.exists(cyc) ? sched_d[cyc] : '0;
            if (sched_v.exists(cyc)) begin
                sched_v.delete(cyc);
                sched_d.delete(cyc);
            end
            chk("grant", grant, eg);
            chk("sram_en", sram_en, een);
            chk("sram_wen", sram_wen, ewen);
            chk("sram_addr", sram_addr, ea);
            chk("sram_wdata", sram_wdata, ewd);
            chk("rd_valid", rd_valid, erv);
            chk("rd_data", rd_data, erd);
            chk("addr_err", addr_err, merr);
`ifdef CIM_MEM_COLLISION_CNT_EN
            chk("coll", collision_cnt, coll);
            if ($countones(act) >= 2 && coll < 65535) coll++;
`endif
            if (win >= 0) begin
                if (wreq[win]) begin
                    if (!oob) mmem[addr[win]] = wdat[win];
                end else begin
                    sched_v[cyc + LAT] = eg;
                    sched_d[cyc + LAT] = oob ? '0 : mmem[addr[win]];
                end
                if (oob) merr = 1'b1;
            end
            for (int i = 0; i < NS; i++)
                wait_c[i] = (!act[i] || i == win) ? 0 : wait_c[i] + 1;
            last_gnt = eg;
        end
    end

    initial begin
        int kind;
        int load;
        rst  = 1'b1;
        rreq = '0;
        wreq = '0;
        addr = '0;
        wdat = '0;
        repeat (3) tick;
        rst = 1'b0;
        tick;

        // write then read-after-write from another source
        wreq[2] = 1'b1; addr[2] = 6'd10; wdat[2] = 16'h1234;
        tick;
        wreq[2] = 1'b0; rreq[3] = 1'b1; addr[3] = 6'd10;
        @(negedge clk);
        chk("raw_grant", grant, 5'b01000);
        tick;
        rreq[3] = 1'b0;
        repeat (LAT - 1) tick;
        @(negedge clk);
        chk("raw_rv", rd_valid, 5'b01000);
        chk("raw_rd", rd_data, 16'h1234);
        tick;

        // starvation promotion
        rreq[0] = 1'b1; addr[0] = 6'd1;
        rreq[4] = 1'b1; addr[4] = 6'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("starve_g", grant, (k == 4) ? 5'b10000 : 5'b00001);
            tick;
        end
        rreq = '0;
        repeat (LAT + 1) tick;

        // read+write same cycle
        rreq[1] = 1'b1; wreq[1] = 1'b1; addr[1] = 6'd7; wdat[1] = 16'hBEEF;
        @(negedge clk);
        chk("rw_g1", grant, 5'b00010);
        chk("rw_wen", sram_wen, 1);
        tick;
        wreq[1] = 1'b0;
        @(negedge clk);
        chk("rw_g2", grant, 5'b00010);
        chk("rw_ren", {sram_en, sram_wen}, 2'b10);
        tick;
        rreq[1] = 1'b0;
        repeat (LAT - 1) tick;
        @(negedge clk);
        chk("rw_rv", rd_valid, 5'b00010);
        chk("rw_rd", rd_data, 16'hBEEF);
        repeat (2) tick;

        // out-of-range read
        rreq[2] = 1'b1; addr[2] = 6'd48;
        @(negedge clk);
        chk("oob_g", grant, 5'b00100);
        chk("oob_en", sram_en, 0);
        tick;
        rreq[2] = 1'b0;
        repeat (LAT - 1) tick;
        @(negedge clk);
        chk("oob_rv", rd_valid, 5'b00100);
        chk("oob_rd", rd_data, 0);
        chk("oob_err", addr_err, 1);
        repeat (3) tick;
        @(negedge clk);
        chk("oob_sticky", addr_err, 1);
        tick;

        // reset right after a read grant
        rreq[0] = 1'b1; addr[0] = 6'd3;
        @(negedge clk);
        chk("rr_g", grant, 5'b00001);
        tick;
        rreq[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rr_rst_g", grant, 0);
        chk("rr_rst_err", addr_err, 0);
        tick;
        rst = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("rr_no_rv", rd_valid, 0);
            tick;
        end

`ifdef CIM_MEM_COLLISION_CNT_EN
        rreq[0] = 1'b1; addr[0] = 6'd4;
        rreq[1] = 1'b1; addr[1] = 6'd5;
        repeat (3) tick;
        rreq = '0;
        @(negedge clk);
        chk("coll_3", collision_cnt, 3);
        repeat (LAT + 1) tick;
`endif

        // randomized traffic honouring the hold-until-granted rule
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst  = 1'b1;
                rreq = '0;
                wreq = '0;
                tick;
                tick;
                rst = 1'b0;
            end
            load = (c < 1000) ? 70 : 30;
            for (int i = 0; i < NS; i++) begin
                if (last_gnt[i]) begin
                    if (wreq[i]) wreq[i] = 1'b0;
                    else rreq[i] = 1'b0;
                end
                if (!rreq[i] && !wreq[i] && $urandom_range(0, 99) < load) begin
                    kind    = $urandom_range(0, 9);
                    rreq[i] = (kind < 5) || (kind == 9);
                    wreq[i] = (kind >= 5);
                    if ($urandom_range(0, 99) < 2)
                        addr[i] = AW'(48 + $urandom_range(0, 15));
                    else
                        addr[i] = AW'($urandom_range(0, 15));
                    wdat[i] = DW'($urandom);
                end
            end
            tick;
        end
        rreq = '0;
        wreq = '0;
        repeat (LAT + 2) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
